// File: rtl/lsu_pkg.sv
// ---------------------------------------------------------------------------
// lsu_pkg
// Shared definitions for the load/store memory-access stage:
//   - op_size encodings (SZ_*)
//   - register-file write-type codes (RFW_*) understood by the MIPS regfile
//   - FSM state enumeration
//   - rf_code(): maps a load op to its register-file write-type code
// ---------------------------------------------------------------------------
package lsu_pkg;

  // op_size encodings; 2'b11 is reserved and handled exactly like a word.
  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  // Register-file write-type codes. The register file performs the final
  // sign/zero extension based on this code.
  localparam logic [2:0] RFW_NONE = 3'b000;
  localparam logic [2:0] RFW_LW   = 3'b001;
  localparam logic [2:0] RFW_LH   = 3'b010;
  localparam logic [2:0] RFW_LB   = 3'b011;
  localparam logic [2:0] RFW_LHU  = 3'b100;
  localparam logic [2:0] RFW_LBU  = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WB     = 2'd2
  } lsu_state_e;

  // Write-type code for a load. A load to $0 still performs the bus read
  // but must never write the register file.
  function automatic logic [2:0] rf_code(input logic [1:0] size,
                                         input logic       is_unsigned,
                                         input logic [4:0] rd);
    logic [2:0] code;
    case (size)
      SZ_HALF: code = is_unsigned ? RFW_LHU : RFW_LH;
      SZ_BYTE: code = is_unsigned ? RFW_LBU : RFW_LB;
      default: code = RFW_LW;
    endcase
    if (rd == 5'd0) begin
      code = RFW_NONE;
    end
    return code;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// ---------------------------------------------------------------------------
// lsu_lane_align
// Purely combinational lane steering for a 32-bit little-endian data bus.
//   size     in  2   op size (SZ_WORD / SZ_HALF / SZ_BYTE / reserved=word)
//   addr_lo  in  2   byte address bits [1:0]
//   st_data  in  32  store value, right-justified
//   ld_data  in  32  raw bus read data
//   be       out 4   byte enables
//   st_rep   out 32  store value replicated across all lanes
//   ld_shift out 32  read data shifted so the addressed lane sits at bit 0
// Offending low address bits of misaligned accesses are simply dropped
// here: a word ignores addr_lo entirely and a half only looks at addr_lo[1].
// ---------------------------------------------------------------------------
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] st_data,
  input  logic [31:0] ld_data,
  output logic [3:0]  be,
  output logic [31:0] st_rep,
  output logic [31:0] ld_shift
);

  always_comb begin
    be       = 4'b1111;
    st_rep   = st_data;
    ld_shift = ld_data;
    case (size)
      SZ_HALF: begin
        be       = addr_lo[1] ? 4'b1100 : 4'b0011;
        st_rep   = {2{st_data[15:0]}};
        ld_shift = ld_data >> {addr_lo[1], 4'b0000};
      end
      SZ_BYTE: begin
        be       = 4'b0001 << addr_lo;
        st_rep   = {4{st_data[7:0]}};
        ld_shift = ld_data >> {addr_lo, 3'b000};
      end
      default: begin
        be       = 4'b1111;
        st_rep   = st_data;
        ld_shift = ld_data;
      end
    endcase
  end

endmodule

// File: rtl/lsu_mem_stage.sv
// ---------------------------------------------------------------------------
// lsu_mem_stage
// Load/store memory-access stage feeding the MIPS register file. Accepts one
// op at a time, runs a single req/ack transaction on the data bus and, for
// loads, presents lane-aligned data plus a write-type code for one cycle.
//
// Parameters:
//   TIMEOUT_CYC  cycles (1..255) mem_req is held without mem_ack before the
//                access is aborted with a bus_err pulse.
//
// Configuration macro:
//   LSU_MISALIGN_TRAP_EN  defined  : misaligned half/word ops are accepted,
//                                    issue no bus request and pulse misalign
//                                    in the cycle after acceptance.
//                         undefined: misaligned low address bits are ignored
//                                    and misalign is tied low.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   op_valid/op_ready        op handshake (op_ready only in IDLE)
//   op_load, op_size, op_unsigned, op_addr, op_wdata, op_rd   op fields
//   mem_req/mem_ack          bus handshake; mem_req held until ack/timeout
//   mem_we, mem_addr, mem_be, mem_wdata, mem_rdata            bus fields
//   rf_wr, rf_a3, rf_wd      register-file write-type code, dest, data
//   busy                     state != IDLE
//   bus_err                  one-cycle pulse on timeout
//   misalign                 one-cycle pulse on a trapped misaligned op
//
// Timing: op accepted at edge 0, mem_req from cycle 1, ack sampled at edge
// k, rf_wr valid in cycle k+1, op_ready again in cycle k+2.
// ---------------------------------------------------------------------------
module lsu_mem_stage
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        op_valid,
  output logic        op_ready,
  input  logic        op_load,
  input  logic [1:0]  op_size,
  input  logic        op_unsigned,
  input  logic [31:0] op_addr,
  input  logic [31:0] op_wdata,
  input  logic [4:0]  op_rd,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [2:0]  rf_wr,
  output logic [4:0]  rf_a3,
  output logic [31:0] rf_wd,
  output logic        busy,
  output logic        bus_err,
  output logic        misalign
);

  // The timeout fires on the cycle whose counter value equals this, so
  // mem_req stays high for exactly TIMEOUT_CYC cycles.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 1);

  lsu_state_e  state_q, state_d;

  logic        mem_req_q,   mem_req_d;
  logic        mem_we_q,    mem_we_d;
  logic [31:0] mem_addr_q,  mem_addr_d;
  logic [3:0]  mem_be_q,    mem_be_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [2:0]  rf_wr_q,     rf_wr_d;
  logic [4:0]  rf_a3_q,     rf_a3_d;
  logic [31:0] rf_wd_q,     rf_wd_d;
  logic        bus_err_q,   bus_err_d;

  // Latched op context used while the access is in flight.
  logic        load_q,    load_d;
  logic [1:0]  size_q,    size_d;
  logic [1:0]  addr_lo_q, addr_lo_d;
  logic [4:0]  rd_q,      rd_d;
  logic [2:0]  code_q,    code_d;
  logic [7:0]  cnt_q,     cnt_d;

`ifdef LSU_MISALIGN_TRAP_EN
  logic        misalign_q, misalign_d;
  logic        op_misaligned;
`endif

  // One lane-align instance serves both directions: in IDLE it sees the
  // incoming op (for be / store replication), afterwards the latched op
  // (for steering the read data on ack).
  logic [1:0]  al_size;
  logic [1:0]  al_addr_lo;
  logic [3:0]  al_be;
  logic [31:0] al_st_rep;
  logic [31:0] al_ld_shift;

  assign al_size    = (state_q == ST_IDLE) ? op_size      : size_q;
  assign al_addr_lo = (state_q == ST_IDLE) ? op_addr[1:0] : addr_lo_q;

  lsu_lane_align u_lane_align (
    .size     (al_size),
    .addr_lo  (al_addr_lo),
    .st_data  (op_wdata),
    .ld_data  (mem_rdata),
    .be       (al_be),
    .st_rep   (al_st_rep),
    .ld_shift (al_ld_shift)
  );

`ifdef LSU_MISALIGN_TRAP_EN
  // Half with addr[0] set, or word/reserved with any low bit set.
  always_comb begin
    case (op_size)
      SZ_HALF: op_misaligned = op_addr[0];
      SZ_BYTE: op_misaligned = 1'b0;
      default: op_misaligned = (op_addr[1:0] != 2'b00);
    endcase
  end
`endif

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;
    rf_wr_d     = RFW_NONE;
    rf_a3_d     = rf_a3_q;
    rf_wd_d     = rf_wd_q;
    bus_err_d   = 1'b0;
    load_d      = load_q;
    size_d      = size_q;
    addr_lo_d   = addr_lo_q;
    rd_d        = rd_q;
    code_d      = code_q;
    cnt_d       = cnt_q;
`ifdef LSU_MISALIGN_TRAP_EN
    misalign_d  = 1'b0;
`endif

    case (state_q)
      ST_IDLE: begin
        if (op_valid) begin
          load_d      = op_load;
          size_d      = op_size;
          addr_lo_d   = op_addr[1:0];
          rd_d        = op_rd;
          code_d      = rf_code(op_size, op_unsigned, op_rd);
          cnt_d       = 8'd0;
          mem_addr_d  = {op_addr[31:2], 2'b00};
          mem_we_d    = ~op_load;
          mem_be_d    = al_be;
          mem_wdata_d = al_st_rep;
          mem_req_d   = 1'b1;
          state_d     = ST_ACCESS;
`ifdef LSU_MISALIGN_TRAP_EN
          // Trapped op: consume it, keep the bus quiet and stay in IDLE.
          if (op_misaligned) begin
            mem_req_d  = 1'b0;
            mem_we_d   = 1'b0;
            mem_be_d   = 4'b0000;
            misalign_d = 1'b1;
            state_d    = ST_IDLE;
          end
`endif
        end
      end

      ST_ACCESS: begin
        if (mem_ack) begin
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          mem_be_d  = 4'b0000;
          if (load_q) begin
            rf_wd_d = al_ld_shift;
            rf_a3_d = rd_q;
            rf_wr_d = code_q;
            state_d = ST_WB;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (cnt_q == TO_LAST) begin
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          mem_be_d  = 4'b0000;
          bus_err_d = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      ST_WB: begin
        // rf_wr was raised on the ack edge and defaults back to NONE here.
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'd0;
      mem_be_q    <= 4'b0000;
      mem_wdata_q <= 32'd0;
      rf_wr_q     <= RFW_NONE;
      rf_a3_q     <= 5'd0;
      rf_wd_q     <= 32'd0;
      bus_err_q   <= 1'b0;
      load_q      <= 1'b0;
      size_q      <= SZ_WORD;
      addr_lo_q   <= 2'b00;
      rd_q        <= 5'd0;
      code_q      <= RFW_NONE;
      cnt_q       <= 8'd0;
`ifdef LSU_MISALIGN_TRAP_EN
      misalign_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
      rf_wr_q     <= rf_wr_d;
      rf_a3_q     <= rf_a3_d;
      rf_wd_q     <= rf_wd_d;
      bus_err_q   <= bus_err_d;
      load_q      <= load_d;
      size_q      <= size_d;
      addr_lo_q   <= addr_lo_d;
      rd_q        <= rd_d;
      code_q      <= code_d;
      cnt_q       <= cnt_d;
`ifdef LSU_MISALIGN_TRAP_EN
      misalign_q  <= misalign_d;
`endif
    end
  end

  assign op_ready  = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_be    = mem_be_q;
  assign mem_wdata = mem_wdata_q;
  assign rf_wr     = rf_wr_q;
  assign rf_a3     = rf_a3_q;
  assign rf_wd     = rf_wd_q;
  assign bus_err   = bus_err_q;
`ifdef LSU_MISALIGN_TRAP_EN
  assign misalign  = misalign_q;
`else
  assign misalign  = 1'b0;
`endif

endmodule

// File: tb/tb_lsu_mem_stage.sv
// ---------------------------------------------------------------------------
// tb_lsu_mem_stage
// Directed bench for lsu_mem_stage (TIMEOUT_CYC = 4). Stimulus pushes the
// hand-computed bus request / writeback / pulse it expects into queues; a
// negedge monitor pops and compares whenever the DUT presents one.
// ---------------------------------------------------------------------------
module tb_lsu_mem_stage;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        op_valid = 1'b0;
  logic        op_ready;
  logic        op_load = 1'b0;
  logic [1:0]  op_size = 2'b00;
  logic        op_unsigned = 1'b0;
  logic [31:0] op_addr = 32'd0;
  logic [31:0] op_wdata = 32'd0;
  logic [4:0]  op_rd = 5'd0;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = 32'd0;
  logic [2:0]  rf_wr;
  logic [4:0]  rf_a3;
  logic [31:0] rf_wd;
  logic        busy;
  logic        bus_err;
  logic        misalign;

  always #5 clk = ~clk;

  lsu_mem_stage #(.TIMEOUT_CYC(4)) dut (
    .clk(clk), .rst(rst),
    .op_valid(op_valid), .op_ready(op_ready), .op_load(op_load),
    .op_size(op_size), .op_unsigned(op_unsigned), .op_addr(op_addr),
    .op_wdata(op_wdata), .op_rd(op_rd),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata),
    .rf_wr(rf_wr), .rf_a3(rf_a3), .rf_wd(rf_wd),
    .busy(busy), .bus_err(bus_err), .misalign(misalign)
  );

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic        we;
    logic [31:0] wdata;
    logic        chk_wd;
  } bus_t;

  typedef struct {
    logic [2:0]  code;
    logic [4:0]  a3;
    logic [31:0] wd;
    logic [31:0] mask;
  } wb_t;

  bus_t bus_q[$];
  wb_t  wb_q[$];
  bit   err_q[$];
  bit   mis_q[$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h required=0x%08h", nm, act, exp);
    end
  endtask

  task automatic push_bus(input logic [31:0] a, input logic [3:0] be, input logic we,
                          input logic [31:0] wd, input logic cw);
    bus_t b;
    b.addr = a; b.be = be; b.we = we; b.wdata = wd; b.chk_wd = cw;
    bus_q.push_back(b);
  endtask

  task automatic push_wb(input logic [2:0] code, input logic [4:0] a3,
                         input logic [31:0] wd, input logic [31:0] mask);
    wb_t w;
    w.code = code; w.a3 = a3; w.wd = wd; w.mask = mask;
    wb_q.push_back(w);
  endtask

  // ---------------- monitor ----------------
  logic        req_prev = 1'b0;
  logic [31:0] snap_addr = 32'd0;
  bus_t        mb;
  wb_t         mw;

  always @(negedge clk) begin
    if (rst) begin
      req_prev <= 1'b0;
    end else begin
      if (mem_req && !req_prev) begin
        if (bus_q.size() == 0) begin
          chk("unexpected_req", 32'(mem_req), 32'd0);
        end else begin
          mb = bus_q.pop_front();
          chk("bus_addr", mem_addr, mb.addr);
          chk("bus_be", 32'(mem_be), 32'(mb.be));
          chk("bus_we", 32'(mem_we), 32'(mb.we));
          if (mb.chk_wd) chk("bus_wdata", mem_wdata, mb.wdata);
          $display("bus req addr=0x%08h be=%b we=%0d wdata=0x%08h", mem_addr, mem_be, mem_we, mem_wdata);
        end
        snap_addr <= mem_addr;
      end else if (mem_req) begin
        chk("bus_addr_stable", mem_addr, snap_addr);
      end
      if (rf_wr != RFW_NONE) begin
        if (wb_q.size() == 0) begin
          chk("unexpected_wb", 32'(rf_wr), 32'(RFW_NONE));
        end else begin
          mw = wb_q.pop_front();
          chk("wb_code", 32'(rf_wr), 32'(mw.code));
          chk("wb_a3", 32'(rf_a3), 32'(mw.a3));
          chk("wb_data", rf_wd & mw.mask, mw.wd & mw.mask);
          $display("writeback code=%b a3=%0d wd=0x%08h", rf_wr, rf_a3, rf_wd);
        end
      end
      if (bus_err) begin
        if (err_q.size() == 0) chk("unexpected_bus_err", 32'(bus_err), 32'd0);
        else begin
          void'(err_q.pop_front());
          chk("bus_err_pulse", 32'(bus_err), 32'd1);
          $display("bus_err pulse");
        end
      end
      if (misalign) begin
        if (mis_q.size() == 0) chk("unexpected_misalign", 32'(misalign), 32'd0);
        else begin
          void'(mis_q.pop_front());
          chk("misalign_pulse", 32'(misalign), 32'd1);
          $display("misalign pulse");
        end
      end
      req_prev <= mem_req;
    end
  end

  // ---------------- driver helpers ----------------
  task automatic wait_ready();
    int n = 0;
    while (!op_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!op_ready) chk("op_ready_timeout", 32'(op_ready), 32'd1);
  endtask

  // Returns at #1 after the accept edge (cycle 1).
  task automatic send(input logic ld, input logic [1:0] sz, input logic uns,
                      input logic [31:0] addr, input logic [31:0] wd, input logic [4:0] rd);
    @(posedge clk); #1;
    wait_ready();
    op_valid = 1'b1; op_load = ld; op_size = sz; op_unsigned = uns;
    op_addr = addr; op_wdata = wd; op_rd = rd;
    @(posedge clk); #1;
    op_valid = 1'b0;
  endtask

  task automatic do_ack(input int delay, input logic [31:0] rdata);
    repeat (delay) begin
      @(posedge clk); #1;
    end
    mem_ack = 1'b1; mem_rdata = rdata;
    @(posedge clk); #1;
    mem_ack = 1'b0; mem_rdata = 32'd0;
  endtask

  task automatic run_load(input logic [1:0] sz, input logic uns, input logic [31:0] addr,
                          input logic [4:0] rd, input int delay, input logic [31:0] rdata,
                          input logic [2:0] exp_code);
    send(1'b1, sz, uns, addr, 32'hFFFF_FFFF, rd);
    chk("req_cycle1", 32'(mem_req), 32'd1);
    chk("busy_access", 32'(busy), 32'd1);
    do_ack(delay, rdata);
    chk("wb_k_plus_1", 32'(rf_wr), 32'(exp_code));
    chk("req_drop_ld", 32'(mem_req), 32'd0);
    @(posedge clk); #1;
    chk("ready_k_plus_2", 32'(op_ready), 32'd1);
    chk("wb_one_cycle", 32'(rf_wr), 32'(RFW_NONE));
  endtask

  task automatic run_store(input logic [1:0] sz, input logic [31:0] addr,
                           input logic [31:0] wd, input int delay);
    send(1'b0, sz, 1'b0, addr, wd, 5'd31);
    chk("req_cycle1_st", 32'(mem_req), 32'd1);
    do_ack(delay, 32'h0);
    chk("req_drop_st", 32'(mem_req), 32'd0);
    chk("ready_after_st", 32'(op_ready), 32'd1);
    chk("no_wb_st", 32'(rf_wr), 32'(RFW_NONE));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    #1 rst = 1'b1;
    #1;
    chk("rst_op_ready", 32'(op_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_be", 32'(mem_be), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_rf_wr", 32'(rf_wr), 32'd0);
    chk("rst_rf_a3", 32'(rf_a3), 32'd0);
    chk("rst_rf_wd", rf_wd, 32'd0);
    chk("rst_bus_err", 32'(bus_err), 32'd0);
    chk("rst_misalign", 32'(misalign), 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    // sb 0x80 at 0x103: lane 3, low byte replicated.
    push_bus(32'h0000_0100, 4'b1000, 1'b1, 32'h8080_8080, 1'b1);
    run_store(SZ_BYTE, 32'h0000_0103, 32'h1234_5680, 1);

    // lb 0x103: rdata 0x80AABBCC >> 24 -> 0x80.
    push_bus(32'h0000_0100, 4'b1000, 1'b0, 32'h0, 1'b0);
    push_wb(RFW_LB, 5'd3, 32'h0000_0080, 32'h0000_00FF);
    run_load(SZ_BYTE, 1'b0, 32'h0000_0103, 5'd3, 0, 32'h80AA_BBCC, RFW_LB);

    // lhu 0x202: upper half 0xBEEF.
    push_bus(32'h0000_0200, 4'b1100, 1'b0, 32'h0, 1'b0);
    push_wb(RFW_LHU, 5'd4, 32'h0000_BEEF, 32'h0000_FFFF);
    run_load(SZ_HALF, 1'b1, 32'h0000_0202, 5'd4, 2, 32'hBEEF_1234, RFW_LHU);

    // lw to $0: bus read happens, no writeback.
    push_bus(32'h0000_0400, 4'b1111, 1'b0, 32'h0, 1'b0);
    run_load(SZ_WORD, 1'b0, 32'h0000_0400, 5'd0, 1, 32'hCAFE_F00D, RFW_NONE);

    // sh at 0x10A: upper lanes, low half replicated.
    push_bus(32'h0000_0108, 4'b1100, 1'b1, 32'hABCD_ABCD, 1'b1);
    run_store(SZ_HALF, 32'h0000_010A, 32'h1234_ABCD, 0);

    // lh 0x10A signed.
    push_bus(32'h0000_0108, 4'b1100, 1'b0, 32'h0, 1'b0);
    push_wb(RFW_LH, 5'd10, 32'h0000_5555, 32'h0000_FFFF);
    run_load(SZ_HALF, 1'b0, 32'h0000_010A, 5'd10, 0, 32'h5555_7777, RFW_LH);

    // lh 0x200 lower half.
    push_bus(32'h0000_0200, 4'b0011, 1'b0, 32'h0, 1'b0);
    push_wb(RFW_LH, 5'd11, 32'h0000_C3C3, 32'h0000_FFFF);
    run_load(SZ_HALF, 1'b0, 32'h0000_0200, 5'd11, 0, 32'hAAAA_C3C3, RFW_LH);

    // lbu 0x101: lane 1 -> 0x56.
    push_bus(32'h0000_0100, 4'b0010, 1'b0, 32'h0, 1'b0);
    push_wb(RFW_LBU, 5'd9, 32'h0000_0056, 32'h0000_00FF);
    run_load(SZ_BYTE, 1'b1, 32'h0000_0101, 5'd9, 1, 32'h1234_5678, RFW_LBU);

    // sw 0x500.
    push_bus(32'h0000_0500, 4'b1111, 1'b1, 32'hDEAD_BEEF, 1'b1);
    run_store(SZ_WORD, 32'h0000_0500, 32'hDEAD_BEEF, 0);

    // Reserved size behaves as word; op_unsigned ignored.
    push_bus(32'h0000_0604, 4'b1111, 1'b0, 32'h0, 1'b0);
    push_wb(RFW_LW, 5'd12, 32'h0BAD_F00D, 32'hFFFF_FFFF);
    run_load(SZ_RSVD, 1'b1, 32'h0000_0604, 5'd12, 0, 32'h0BAD_F00D, RFW_LW);

    // Timeout: no ack, mem_req held for 4 cycles, then bus_err.
    push_bus(32'h0000_0800, 4'b1111, 1'b0, 32'h0, 1'b0);
    err_q.push_back(1'b1);
    send(1'b1, SZ_WORD, 1'b0, 32'h0000_0800, 32'h0, 5'd5);
    n = 0;
    while (mem_req && n < 20) begin
      n++;
      @(posedge clk); #1;
    end
    chk("timeout_req_cycles", 32'(n), 32'd4);
    chk("timeout_bus_err", 32'(bus_err), 32'd1);
    chk("timeout_idle", 32'(op_ready), 32'd1);
    @(posedge clk); #1;
    chk("timeout_err_one_cycle", 32'(bus_err), 32'd0);
    chk("timeout_no_wb", 32'(rf_wr), 32'(RFW_NONE));

    // Misaligned lw at 0x301.
`ifdef LSU_MISALIGN_TRAP_EN
    mis_q.push_back(1'b1);
    send(1'b1, SZ_WORD, 1'b0, 32'h0000_0301, 32'h0, 5'd7);
    chk("mis_pulse", 32'(misalign), 32'd1);
    chk("mis_no_req", 32'(mem_req), 32'd0);
    @(posedge clk); #1;
    chk("mis_one_cycle", 32'(misalign), 32'd0);
    chk("mis_no_req2", 32'(mem_req), 32'd0);
    chk("mis_no_wb", 32'(rf_wr), 32'(RFW_NONE));
    chk("mis_idle", 32'(op_ready), 32'd1);
`else
    push_bus(32'h0000_0300, 4'b1111, 1'b0, 32'h0, 1'b0);
    push_wb(RFW_LW, 5'd7, 32'h1122_3344, 32'hFFFF_FFFF);
    run_load(SZ_WORD, 1'b0, 32'h0000_0301, 5'd7, 0, 32'h1122_3344, RFW_LW);
    chk("mis_tied_low", 32'(misalign), 32'd0);
`endif

    // Reset mid-ACCESS: mem_req falls without a clock edge, late ack ignored.
    push_bus(32'h0000_0700, 4'b1111, 1'b0, 32'h0, 1'b0);
    send(1'b1, SZ_WORD, 1'b0, 32'h0000_0700, 32'h0, 5'd6);
    chk("rst_mid_req_before", 32'(mem_req), 32'd1);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    chk("rst_mid_req_async", 32'(mem_req), 32'd0);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    mem_ack = 1'b1; mem_rdata = 32'h7777_7777;
    @(posedge clk); #1;
    mem_ack = 1'b0; mem_rdata = 32'h0;
    for (int i = 0; i < 3; i++) begin
      chk("rst_late_ack_no_wb", 32'(rf_wr), 32'(RFW_NONE));
      @(posedge clk); #1;
    end

    repeat (2) @(posedge clk);
    #1;
    chk("bus_q_drained", 32'(bus_q.size()), 32'd0);
    chk("wb_q_drained", 32'(wb_q.size()), 32'd0);
    chk("err_q_drained", 32'(err_q.size()), 32'd0);
    chk("mis_q_drained", 32'(mis_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
